// File: rtl/score_pkg.sv
// Shared types and point constants for the score tracker.
package score_pkg;

  typedef enum logic [1:0] {
    GR_MISS    = 2'd0,
    GR_OK      = 2'd1,
    GR_GOOD    = 2'd2,
    GR_PERFECT = 2'd3
  } grade_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int PTS_OK       = 50;
  localparam int PTS_GOOD     = 100;
  localparam int PTS_PERFECT  = 300;
  localparam int MISS_PENALTY = 25;

endpackage

// File: rtl/score_points.sv
// Maps a hit grade and the current multiplier to the points it is worth.
module score_points
  import score_pkg::*;
(
  input  grade_e      i_grade,
  input  logic [2:0]  i_mult,
  output logic [11:0] o_points
);

  logic [11:0] w_base;

  always_comb begin
    w_base = 12'd0;
    case (i_grade)
      GR_OK:      w_base = 12'(PTS_OK);
      GR_GOOD:    w_base = 12'(PTS_GOOD);
      GR_PERFECT: w_base = 12'(PTS_PERFECT);
      default:    w_base = 12'd0;
    endcase
  end

  // Largest product is 300 * 4 = 1200, well inside 12 bits.
  assign o_points = w_base * {9'd0, i_mult};

endmodule

// File: rtl/score_tracker.sv
// Rhythm-game score/streak tracker with saturating counters.
// Optional: define SCORE_MISS_PENALTY_EN to make a miss cost points.
//
// state   | meaning
// IDLE    | no game since reset, hits ignored
// RUN     | game in progress, hits scored
// DONE    | game ended, final score/streak held
module score_tracker
  import score_pkg::*;
#(
  parameter int MAX_SCORE   = 999999,
  parameter int MAX_STREAK  = 999,
  parameter int STREAK_STEP = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        game_over,
  input  logic        hit_valid,
  input  logic [1:0]  hit_grade,
  output logic [19:0] score,
  output logic [9:0]  streak,
  output logic [2:0]  multiplier,
  output logic        running,
  output logic        score_upd
);

  state_e      r_state;
  logic [19:0] r_score;
  logic [9:0]  r_streak;
  logic        r_upd;

  logic [9:0]  w_step;
  logic [11:0] w_points;
  logic [20:0] w_sum;
  logic [19:0] w_hit_score;
  logic [19:0] w_next_score;
  logic [9:0]  w_hit_streak;
  logic [9:0]  w_next_streak;
  logic        w_do_hit;

  assign w_step     = r_streak / 10'(STREAK_STEP);
  assign multiplier = (w_step >= 10'd3) ? 3'd4 : 3'(w_step + 10'd1);

  score_points u_points (
    .i_grade  (grade_e'(hit_grade)),
    .i_mult   (multiplier),
    .o_points (w_points)
  );

  assign w_sum    = {1'b0, r_score} + {9'd0, w_points};
  assign w_do_hit = hit_valid && (r_state == ST_RUN);

  always_comb begin
    w_hit_score  = r_score;
    w_hit_streak = r_streak;
    if (grade_e'(hit_grade) == GR_MISS) begin
      w_hit_streak = '0;
`ifdef SCORE_MISS_PENALTY_EN
      w_hit_score = (r_score >= 20'(MISS_PENALTY)) ? r_score - 20'(MISS_PENALTY) : '0;
`endif
    end else begin
      w_hit_score = (w_sum > 21'(MAX_SCORE)) ? 20'(MAX_SCORE) : w_sum[19:0];
      if (r_streak < 10'(MAX_STREAK)) w_hit_streak = r_streak + 10'd1;
    end
  end

  // start has priority over everything, including a same-cycle hit.
  always_comb begin
    w_next_score  = r_score;
    w_next_streak = r_streak;
    if (start) begin
      w_next_score  = '0;
      w_next_streak = '0;
    end else if (w_do_hit) begin
      w_next_score  = w_hit_score;
      w_next_streak = w_hit_streak;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_score  <= '0;
      r_streak <= '0;
      r_upd    <= 1'b0;
    end else begin
      r_score  <= w_next_score;
      r_streak <= w_next_streak;
      r_upd    <= (w_next_score != r_score);
      case (r_state)
        ST_IDLE: if (start) r_state <= ST_RUN;
        ST_RUN:  if (!start && game_over) r_state <= ST_DONE;
        ST_DONE: if (start) r_state <= ST_RUN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign score     = r_score;
  assign streak    = r_streak;
  assign running   = (r_state == ST_RUN);
  assign score_upd = r_upd;

endmodule
